regfile_mp: RTL

- Parametrised multi-port register file; successor to the single-write, two-read core register file.
- Adds configurable width, depth and read/write port counts, and an optional hardwired-zero register.
- Adds optional write-to-read bypass and a per-register busy scoreboard (claim on issue, release on writeback).
- Sits between decode (reads, claims) and writeback (writes) in the core pipeline.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 88 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

  // Register index that reads as zero when the hardwired-zero option is enabled.
  localparam int unsigned ZERO_ADDR = 0;

  // Address width needed to index `depth` registers (never less than one bit).
  function automatic int unsigned rf_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on claim (issue), cleared on writeback.
module rf_scoreboard import rf_pkg::*; #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = rf_aw(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE-1:0][AW-1:0]    waddr,
  input  logic                         claim_en,
  input  logic [AW-1:0]                claim_addr,
  output logic [DEPTH-1:0]             busy_vec
);

  logic [DEPTH-1:0] busy_q, busy_d;

  // True when an address names a real register that accepts writes and claims.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == AW'(ZERO_ADDR)));
  endfunction

  // Next state: writebacks release first, then a claim re-marks, so a claim wins.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && addr_ok(waddr[j])) begin
        busy_d[waddr[j]] = 1'b0;
      end
    end
    if (claim_en && addr_ok(claim_addr)) begin
      busy_d[claim_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[ZERO_ADDR] = 1'b0;
    end
  end

  // Scoreboard state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register,
// write-to-read bypass and a busy scoreboard.
module regfile_mp import rf_pkg::*; #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = rf_aw(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NWRITE-1:0]             wen,
  input  logic [NWRITE-1:0][AW-1:0]     waddr,
  input  logic [NWRITE-1:0][WIDTH-1:0]  wdata,
  input  logic [NREAD-1:0][AW-1:0]      raddr,
  output logic [NREAD-1:0][WIDTH-1:0]   rdata,
  output logic [NREAD-1:0]              rbusy,
  input  logic                          claim_en,
  input  logic [AW-1:0]                 claim_addr,
  output logic [DEPTH-1:0]              busy_vec
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Address is in range and not the hardwired-zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == AW'(ZERO_ADDR)));
  endfunction

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec)
  );

  // Write resolution: ports applied in ascending order so the highest index wins.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && addr_ok(waddr[j])) begin
        mem_d[waddr[j]] = wdata[j];
      end
    end
  end

  // Data array with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes; out-of-range and zero-register reads return 0 and not-busy.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rdata[i] = '0;
      rbusy[i] = 1'b0;
      if (addr_ok(raddr[i])) begin
        rdata[i] = mem_q[raddr[i]];
        rbusy[i] = busy_vec[raddr[i]];
        if (BYPASS != 0) begin
          // Same-cycle writeback: forward data and show the post-release busy bit.
          for (int j = 0; j < NWRITE; j++) begin
            if (wen[j] && (waddr[j] == raddr[i])) begin
              rdata[i] = wdata[j];
              rbusy[i] = claim_en && (claim_addr == raddr[i]);
            end
          end
        end
      end
    end
  end

endmodule
